// File: rtl/btn_speed_ctrl.sv
// Button-driven speed controller: saturating speed level with press lockout,
// prescaler and one-hot LED chaser. Optional SPEED_WRAP_EN makes the level wrap.
module btn_speed_ctrl #(
  parameter int unsigned BASE_TICKS    = 13_500_000,
  parameter int unsigned NUM_LEVELS    = 8,
  parameter int unsigned LOCKOUT_TICKS = 2_700_000,
  parameter int unsigned LED_W         = 6
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          iBtnUp,
  input  logic                          iBtnDn,
  input  logic                          iRun,
  output logic [LED_W-1:0]              oLed,
  output logic [$clog2(NUM_LEVELS)-1:0] oLevel,
  output logic                          oTick,
  output logic                          oBusy
);

  localparam int unsigned LVL_W = $clog2(NUM_LEVELS);
  localparam int unsigned PRE_W = $clog2(BASE_TICKS + 1);
  localparam int unsigned LCK_W = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [PRE_W-1:0] BASE_P   = PRE_W'(BASE_TICKS);
  localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'((LOCKOUT_TICKS == 0) ? 0 : LOCKOUT_TICKS - 1);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_e;

  state_e             state, stateNext;
  logic [PRE_W-1:0]   presc, prescNext;
  logic [PRE_W-1:0]   period;
  logic [LCK_W-1:0]   lockCnt, lockNext;
  logic [LED_W-1:0]   ledNext;
  logic [LVL_W-1:0]   levelNext;
  logic               tickNext, busyNext, accept;

  assign period = BASE_P >> oLevel;
  assign accept = (iBtnUp | iBtnDn) & ~oBusy;

  // Next-state, chaser and level/lockout update
  always_comb begin
    stateNext = state;
    prescNext = presc;
    ledNext   = oLed;
    tickNext  = 1'b0;
    levelNext = oLevel;
    busyNext  = oBusy;
    lockNext  = lockCnt;

    case (state)
      STOP: begin
        prescNext = '0;
        if (iRun) stateNext = RUN;
      end
      RUN: begin
        if (!iRun) begin
          stateNext = STOP;
          prescNext = '0;
        end else if (presc >= period - PRE_W'(1)) begin
          // >= so a level raise past the current count steps immediately
          prescNext = '0;
          tickNext  = 1'b1;
          ledNext   = {oLed[LED_W-2:0], oLed[LED_W-1]};
        end else begin
          prescNext = presc + PRE_W'(1);
        end
      end
      default: stateNext = STOP;
    endcase

    if (accept) begin
      if (LOCKOUT_TICKS != 0) begin
        busyNext = 1'b1;
        lockNext = LCK_LOAD;
      end
      if (iBtnUp && !iBtnDn) begin
        if (oLevel == LVL_MAX) begin
`ifdef SPEED_WRAP_EN
          levelNext = '0;
`else
          levelNext = LVL_MAX;
`endif
        end else begin
          levelNext = oLevel + LVL_W'(1);
        end
      end else if (iBtnDn && !iBtnUp) begin
        if (oLevel == '0) begin
`ifdef SPEED_WRAP_EN
          levelNext = LVL_MAX;
`else
          levelNext = '0;
`endif
        end else begin
          levelNext = oLevel - LVL_W'(1);
        end
      end
    end else if (oBusy) begin
      if (lockCnt == '0) busyNext = 1'b0;
      else               lockNext = lockCnt - LCK_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= STOP;
      presc   <= '0;
      lockCnt <= '0;
      oLed    <= LED_W'(1);
      oLevel  <= '0;
      oTick   <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      state   <= stateNext;
      presc   <= prescNext;
      lockCnt <= lockNext;
      oLed    <= ledNext;
      oLevel  <= levelNext;
      oTick   <= tickNext;
      oBusy   <= busyNext;
    end
  end

endmodule
